// File: rtl/ex_stage_if.sv
// Decode <-> execute bus: ID/EX operands in, stall/forwarding/EX-MEM/HI-LO out.
interface ex_stage_if;
  logic        flush_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic        stallreq_o;
  logic        ex_we_o;
  logic [4:0]  ex_waddr_o;
  logic [31:0] ex_wdata_o;
  logic        mem_we_o;
  logic [4:0]  mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output flush_i, aluop_i, alusel_i, data1_i, data2_i, we_i, waddr_i,
    input  stallreq_o, ex_we_o, ex_waddr_o, ex_wdata_o,
           mem_we_o, mem_waddr_o, mem_wdata_o, hi_o, lo_o
  );

  modport slave (
    input  flush_i, aluop_i, alusel_i, data1_i, data2_i, we_i, waddr_i,
    output stallreq_o, ex_we_o, ex_waddr_o, ex_wdata_o,
           mem_we_o, mem_waddr_o, mem_wdata_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ID/EX latch, logic/shift/move results, HI/LO and a
// bit-serial shift-add multiplier that stalls the front end while it runs.
module ex_stage (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus
);
  localparam int MUL_ITER = 32;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [2:0] RES_NOP  = 3'b000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t  state_reg;
  logic [7:0]  aluop_reg;
  logic [2:0]  alusel_reg;
  logic [31:0] data1_reg, data2_reg;
  logic        we_reg;
  logic [4:0]  waddr_reg;
  logic [31:0] hi_reg, lo_reg;
  logic [63:0] mul_a_reg, acc_reg;
  logic [31:0] mul_b_reg;
  logic [4:0]  cnt_reg;
  logic        neg_reg;
  logic        mem_we_reg;
  logic [4:0]  mem_waddr_reg;
  logic [31:0] mem_wdata_reg;

  logic        is_mul, is_mult, stall;
  logic [31:0] op_a, op_b, result, ex_wdata;
  logic [63:0] product;

  assign is_mult = (aluop_reg == OP_MULT);
  assign is_mul  = is_mult || (aluop_reg == OP_MULTU);
  assign stall   = is_mul && (state_reg != DONE);

  // Signed multiply works on magnitudes; 0x80000000 negates to itself, which
  // is the correct magnitude when read as unsigned.
  assign op_a    = (is_mult && data1_reg[31]) ? -data1_reg : data1_reg;
  assign op_b    = (is_mult && data2_reg[31]) ? -data2_reg : data2_reg;
  assign product = neg_reg ? -acc_reg : acc_reg;

  always_comb begin
    result = 32'd0;
    case (aluop_reg)
      OP_AND:  result = data1_reg & data2_reg;
      OP_OR:   result = data1_reg | data2_reg;
      OP_XOR:  result = data1_reg ^ data2_reg;
      OP_NOR:  result = ~(data1_reg | data2_reg);
      OP_SLL:  result = data2_reg << data1_reg[4:0];
      OP_SRL:  result = data2_reg >> data1_reg[4:0];
      OP_SRA:  result = $signed(data2_reg) >>> data1_reg[4:0];
      OP_MOVZ, OP_MOVN: result = data1_reg;
      OP_MFHI: result = hi_reg;
      OP_MFLO: result = lo_reg;
      default: result = 32'd0;
    endcase
    ex_wdata = (alusel_reg == RES_NOP) ? 32'd0 : result;
  end

  // ID/EX latch: held while the multiplier owns the stage.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      aluop_reg  <= OP_NOP;
      alusel_reg <= RES_NOP;
      data1_reg  <= 32'd0;
      data2_reg  <= 32'd0;
      we_reg     <= 1'b0;
      waddr_reg  <= 5'd0;
    end else if (!stall) begin
      aluop_reg  <= bus.aluop_i;
      alusel_reg <= bus.alusel_i;
      data1_reg  <= bus.data1_i;
      data2_reg  <= bus.data2_i;
      we_reg     <= bus.we_i;
      waddr_reg  <= bus.waddr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      mul_a_reg <= 64'd0;
      mul_b_reg <= 32'd0;
      acc_reg   <= 64'd0;
      cnt_reg   <= 5'd0;
      neg_reg   <= 1'b0;
    end else if (bus.flush_i) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: if (is_mul) begin
          mul_a_reg <= {32'd0, op_a};
          mul_b_reg <= op_b;
          acc_reg   <= 64'd0;
          cnt_reg   <= 5'd0;
          neg_reg   <= is_mult && (data1_reg[31] ^ data2_reg[31]);
          state_reg <= BUSY;
        end
        BUSY: begin
          // b is shifted right, so b[0] here is the original b[cnt].
          if (mul_b_reg[0]) acc_reg <= acc_reg + mul_a_reg;
          mul_a_reg <= mul_a_reg << 1;
          mul_b_reg <= mul_b_reg >> 1;
          cnt_reg   <= cnt_reg + 5'd1;
          if (cnt_reg == 5'(MUL_ITER - 1)) state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else if (!bus.flush_i) begin
      if (state_reg == DONE) begin
        hi_reg <= product[63:32];
        lo_reg <= product[31:0];
      end else if (aluop_reg == OP_MTHI) begin
        hi_reg <= data1_reg;
      end else if (aluop_reg == OP_MTLO) begin
        lo_reg <= data1_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_reg    <= 1'b0;
      mem_waddr_reg <= 5'd0;
      mem_wdata_reg <= 32'd0;
    end else if (bus.flush_i || stall) begin
      mem_we_reg    <= 1'b0;
    end else begin
      mem_we_reg    <= we_reg;
      mem_waddr_reg <= waddr_reg;
      mem_wdata_reg <= ex_wdata;
    end
  end

  assign bus.stallreq_o  = stall;
  assign bus.ex_we_o     = we_reg;
  assign bus.ex_waddr_o  = waddr_reg;
  assign bus.ex_wdata_o  = ex_wdata;
  assign bus.mem_we_o    = mem_we_reg;
  assign bus.mem_waddr_o = mem_waddr_reg;
  assign bus.mem_wdata_o = mem_wdata_reg;
  assign bus.hi_o        = hi_reg;
  assign bus.lo_o        = lo_reg;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, HI/LO moves, multiplier
// timing/results, flush and reset behaviour.
module tb_ex_stage;
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_MOVN  = 8'h0B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [2:0] S_NOP = 3'd0, S_LOGIC = 3'd1, S_SHIFT = 3'd2, S_MOVE = 3'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();
  ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [7:0]  v_op  [10];
  logic [2:0]  v_sel [10];
  logic [31:0] v_d1  [10];
  logic [31:0] v_d2  [10];
  logic [31:0] v_exp [10];

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] d1,
                       input logic [31:0] d2, input logic we, input logic [4:0] wa);
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.data1_i  = d1;
    bus.data2_i  = d2;
    bus.we_i     = we;
    bus.waddr_i  = wa;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.flush_i = 1'b0;
    rst = 1'b1;
    drive(OP_OR, S_LOGIC, 32'h1234, 32'h5678, 1'b1, 5'd7);
    tick; tick;
    $display("txn reset: held 2 cycles");
    n_checks++; if (bus.ex_we_o !== 1'b0 || bus.ex_waddr_o !== 5'd0) begin n_fail++;
      $display("FAIL reset_ex_we: got we=%b waddr=%0d want 0/0", bus.ex_we_o, bus.ex_waddr_o); end
    n_checks++; if (bus.ex_wdata_o !== 32'd0) begin n_fail++;
      $display("FAIL reset_ex_wdata: got %h want 0", bus.ex_wdata_o); end
    n_checks++; if (bus.stallreq_o !== 1'b0 || bus.mem_we_o !== 1'b0 || bus.mem_wdata_o !== 32'd0) begin n_fail++;
      $display("FAIL reset_mem: got stall=%b mem_we=%b mem_wdata=%h want 0", bus.stallreq_o, bus.mem_we_o, bus.mem_wdata_o); end
    n_checks++; if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0) begin n_fail++;
      $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", bus.hi_o, bus.lo_o); end
    rst = 1'b0;
    drive(OP_NOP, S_NOP, 0, 0, 1'b0, 5'd0);
    tick;
  endtask

  task automatic test_forward;
    drive(OP_OR, S_LOGIC, 32'd0, 32'h1100, 1'b1, 5'd1);
    tick;
    $display("txn ori $1=0x1100: ex_wdata=%h", bus.ex_wdata_o);
    n_checks++; if (bus.ex_wdata_o !== 32'h1100 || bus.ex_we_o !== 1'b1 || bus.ex_waddr_o !== 5'd1) begin n_fail++;
      $display("FAIL fwd_ori: got %h we=%b wa=%0d want 00001100/1/1", bus.ex_wdata_o, bus.ex_we_o, bus.ex_waddr_o); end
    drive(OP_OR, S_LOGIC, 32'h1100, 32'h1100, 1'b1, 5'd2);
    tick;
    $display("txn or $2,$1,$1: ex_wdata=%h mem_wdata=%h", bus.ex_wdata_o, bus.mem_wdata_o);
    n_checks++; if (bus.ex_wdata_o !== 32'h1100 || bus.ex_waddr_o !== 5'd2) begin n_fail++;
      $display("FAIL fwd_or: got %h wa=%0d want 00001100/2", bus.ex_wdata_o, bus.ex_waddr_o); end
    n_checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_waddr_o !== 5'd1 || bus.mem_wdata_o !== 32'h1100) begin n_fail++;
      $display("FAIL fwd_mem_ori: got we=%b wa=%0d %h want 1/1/00001100", bus.mem_we_o, bus.mem_waddr_o, bus.mem_wdata_o); end
    drive(OP_NOP, S_NOP, 0, 0, 1'b0, 5'd0);
    tick;
    n_checks++; if (bus.mem_we_o !== 1'b1 || bus.mem_waddr_o !== 5'd2 || bus.mem_wdata_o !== 32'h1100) begin n_fail++;
      $display("FAIL fwd_mem_or: got we=%b wa=%0d %h want 1/2/00001100", bus.mem_we_o, bus.mem_waddr_o, bus.mem_wdata_o); end
  endtask

  task automatic test_alu;
    v_op[0] = OP_AND;  v_sel[0] = S_LOGIC; v_d1[0] = 32'hF0F0FF00; v_d2[0] = 32'h0FF0F0F0; v_exp[0] = 32'h00F0F000;
    v_op[1] = OP_OR;   v_sel[1] = S_LOGIC; v_d1[1] = 32'hF0F0FF00; v_d2[1] = 32'h0FF0F0F0; v_exp[1] = 32'hFFF0FFF0;
    v_op[2] = OP_XOR;  v_sel[2] = S_LOGIC; v_d1[2] = 32'hF0F0FF00; v_d2[2] = 32'h0FF0F0F0; v_exp[2] = 32'hFF000FF0;
    v_op[3] = OP_NOR;  v_sel[3] = S_LOGIC; v_d1[3] = 32'hF0F0FF00; v_d2[3] = 32'h0FF0F0F0; v_exp[3] = 32'h000F000F;
    v_op[4] = OP_SRA;  v_sel[4] = S_SHIFT; v_d1[4] = 32'd4;        v_d2[4] = 32'h80000010; v_exp[4] = 32'hF8000001;
    v_op[5] = OP_SRL;  v_sel[5] = S_SHIFT; v_d1[5] = 32'd4;        v_d2[5] = 32'h80000010; v_exp[5] = 32'h08000001;
    v_op[6] = OP_SLL;  v_sel[6] = S_SHIFT; v_d1[6] = 32'd4;        v_d2[6] = 32'h80000010; v_exp[6] = 32'h00000100;
    v_op[7] = OP_SRA;  v_sel[7] = S_SHIFT; v_d1[7] = 32'h24;       v_d2[7] = 32'h40000000; v_exp[7] = 32'h04000000;
    v_op[8] = OP_MOVN; v_sel[8] = S_MOVE;  v_d1[8] = 32'hCAFEF00D; v_d2[8] = 32'h1;        v_exp[8] = 32'hCAFEF00D;
    v_op[9] = 8'hFE;   v_sel[9] = S_LOGIC; v_d1[9] = 32'hFFFFFFFF; v_d2[9] = 32'hFFFFFFFF; v_exp[9] = 32'h0;
    for (int i = 0; i < 10; i++) begin
      drive(v_op[i], v_sel[i], v_d1[i], v_d2[i], 1'b1, 5'd5);
      tick;
      $display("txn alu op=%h d1=%h d2=%h -> %h", v_op[i], v_d1[i], v_d2[i], bus.ex_wdata_o);
      n_checks++; if (bus.ex_wdata_o !== v_exp[i]) begin n_fail++;
        $display("FAIL alu_vec%0d: got %h want %h", i, bus.ex_wdata_o, v_exp[i]); end
    end
    drive(OP_NOP, S_NOP, 0, 0, 1'b0, 5'd0);
    tick;
  endtask

  task automatic test_hilo_move;
    drive(OP_MTHI, S_NOP, 32'hDEADBEEF, 32'd0, 1'b0, 5'd0);
    tick;
    drive(OP_MFHI, S_MOVE, 32'd0, 32'd0, 1'b1, 5'd3);
    tick;
    $display("txn mthi/mfhi: ex_wdata=%h hi=%h", bus.ex_wdata_o, bus.hi_o);
    n_checks++; if (bus.ex_wdata_o !== 32'hDEADBEEF || bus.ex_we_o !== 1'b1 || bus.ex_waddr_o !== 5'd3) begin n_fail++;
      $display("FAIL mfhi: got %h we=%b wa=%0d want deadbeef/1/3", bus.ex_wdata_o, bus.ex_we_o, bus.ex_waddr_o); end
    drive(OP_MTLO, S_NOP, 32'h13579BDF, 32'd0, 1'b0, 5'd0);
    tick;
    drive(OP_MFLO, S_MOVE, 32'd0, 32'd0, 1'b1, 5'd4);
    tick;
    $display("txn mtlo/mflo: ex_wdata=%h lo=%h", bus.ex_wdata_o, bus.lo_o);
    n_checks++; if (bus.ex_wdata_o !== 32'h13579BDF || bus.hi_o !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL mflo: got %h hi=%h want 13579bdf/deadbeef", bus.ex_wdata_o, bus.hi_o); end
    drive(OP_NOP, S_NOP, 0, 0, 1'b0, 5'd0);
    tick;
  endtask

  task automatic test_mult(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cycles = 0;
    int bad_mem = 0;
    drive(OP_NOP, S_NOP, 0, 0, 1'b0, 5'd0);
    tick;
    drive(op, S_NOP, a, b, 1'b0, 5'd0);
    tick;
    drive(OP_MFLO, S_MOVE, 0, 0, 1'b1, 5'd6);
    while (bus.stallreq_o === 1'b1 && cycles < 100) begin
      if (bus.mem_we_o !== 1'b0) bad_mem++;
      cycles++;
      tick;
    end
    n_checks++; if (cycles != 33) begin n_fail++;
      $display("FAIL mult_stall_len op=%h: got %0d cycles want 33", op, cycles); end
    n_checks++; if (bad_mem != 0) begin n_fail++;
      $display("FAIL mult_mem_bubble op=%h: mem_we high %0d cycles want 0", op, bad_mem); end
    tick;
    $display("txn mult op=%h %h x %h -> hi=%h lo=%h", op, a, b, bus.hi_o, bus.lo_o);
    n_checks++; if (bus.hi_o !== exp_hi || bus.lo_o !== exp_lo) begin n_fail++;
      $display("FAIL mult_result op=%h: got %h_%h want %h_%h", op, bus.hi_o, bus.lo_o, exp_hi, exp_lo); end
    n_checks++; if (bus.ex_wdata_o !== exp_lo || bus.ex_waddr_o !== 5'd6) begin n_fail++;
      $display("FAIL mult_next_mflo: got %h wa=%0d want %h/6", bus.ex_wdata_o, bus.ex_waddr_o, exp_lo); end
    drive(OP_NOP, S_NOP, 0, 0, 1'b0, 5'd0);
    tick;
  endtask

  task automatic test_back_to_back;
    int c1 = 0;
    int c2 = 0;
    drive(OP_NOP, S_NOP, 0, 0, 1'b0, 5'd0);
    tick;
    drive(OP_MULT, S_NOP, 32'd3, 32'd4, 1'b0, 5'd0);
    tick;
    drive(OP_MULTU, S_NOP, 32'h10000, 32'h10000, 1'b0, 5'd0);
    while (bus.stallreq_o === 1'b1 && c1 < 100) begin c1++; tick; end
    tick;
    drive(OP_NOP, S_NOP, 0, 0, 1'b0, 5'd0);
    $display("txn b2b mult 3x4 -> hi=%h lo=%h stall=%b", bus.hi_o, bus.lo_o, bus.stallreq_o);
    n_checks++; if (c1 != 33 || bus.hi_o !== 32'd0 || bus.lo_o !== 32'd12 || bus.stallreq_o !== 1'b1) begin n_fail++;
      $display("FAIL b2b_first: got cyc=%0d %h_%h stall=%b want 33 00000000_0000000c 1", c1, bus.hi_o, bus.lo_o, bus.stallreq_o); end
    while (bus.stallreq_o === 1'b1 && c2 < 100) begin c2++; tick; end
    tick;
    $display("txn b2b multu 0x10000^2 -> hi=%h lo=%h", bus.hi_o, bus.lo_o);
    n_checks++; if (c2 != 33 || bus.hi_o !== 32'd1 || bus.lo_o !== 32'd0) begin n_fail++;
      $display("FAIL b2b_second: got cyc=%0d %h_%h want 33 00000001_00000000", c2, bus.hi_o, bus.lo_o); end
  endtask

  task automatic test_flush;
    drive(OP_OR, S_LOGIC, 32'h5, 32'hA, 1'b1, 5'd9);
    tick;
    bus.flush_i = 1'b1;
    drive(OP_NOP, S_NOP, 0, 0, 1'b0, 5'd0);
    tick;
    bus.flush_i = 1'b0;
    $display("txn flush of or: ex_we=%b mem_we=%b", bus.ex_we_o, bus.mem_we_o);
    n_checks++; if (bus.ex_we_o !== 1'b0 || bus.mem_we_o !== 1'b0) begin n_fail++;
      $display("FAIL flush_alu: got ex_we=%b mem_we=%b want 0/0", bus.ex_we_o, bus.mem_we_o); end
    drive(OP_MULT, S_NOP, 32'd7, 32'd9, 1'b0, 5'd0);
    tick;
    drive(OP_NOP, S_NOP, 0, 0, 1'b0, 5'd0);
    repeat (10) tick;
    n_checks++; if (bus.stallreq_o !== 1'b1) begin n_fail++;
      $display("FAIL flush_pre_stall: got %b want 1", bus.stallreq_o); end
    bus.flush_i = 1'b1;
    tick;
    bus.flush_i = 1'b0;
    $display("txn flush mult at busy 10: stall=%b hi=%h lo=%h", bus.stallreq_o, bus.hi_o, bus.lo_o);
    n_checks++; if (bus.stallreq_o !== 1'b0 || bus.mem_we_o !== 1'b0) begin n_fail++;
      $display("FAIL flush_mult_stall: got stall=%b mem_we=%b want 0/0", bus.stallreq_o, bus.mem_we_o); end
    repeat (40) tick;
    n_checks++; if (bus.hi_o !== 32'd1 || bus.lo_o !== 32'd0) begin n_fail++;
      $display("FAIL flush_hilo: got %h_%h want 00000001_00000000", bus.hi_o, bus.lo_o); end
    drive(OP_MULT, S_NOP, 32'd7, 32'd9, 1'b0, 5'd0);
    tick;
    drive(OP_NOP, S_NOP, 0, 0, 1'b0, 5'd0);
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    $display("txn reset mid-mult: stall=%b hi=%h lo=%h", bus.stallreq_o, bus.hi_o, bus.lo_o);
    n_checks++; if (bus.stallreq_o !== 1'b0 || bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0) begin n_fail++;
      $display("FAIL rst_mid_mult: got stall=%b %h_%h want 0 00000000_00000000", bus.stallreq_o, bus.hi_o, bus.lo_o); end
    repeat (40) tick;
    n_checks++; if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd0) begin n_fail++;
      $display("FAIL rst_hilo_late: got %h_%h want 0", bus.hi_o, bus.lo_o); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_alu();
    test_hilo_move();
    test_mult(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    test_mult(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    test_mult(OP_MULT,  32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000);
    test_back_to_back();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
